// File: rtl/note_ram_sequencer.sv
// Note RAM sequencer: loads UART bytes into the note RAM, plays them back one per beat.
// Optional NOTE_RAM_SEQ_LOOP_EN: replay the song continuously while play_en stays high.
module note_ram_sequencer #(
   parameter int          ADDR_W   = 6,
   parameter int unsigned BEAT_DIV = 50_000_000,
   parameter int          NOTE_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              play_en,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [NOTE_W-1:0] note,
   output logic [ADDR_W:0]   song_len,
   output logic              overflow,
   output logic              play_done,
   output logic [2:0]        state_o
);

   localparam int            DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);
   // HOLD lasts BEAT_DIV-2 cycles; RD_REQ and RD_WAIT make up the rest
   localparam logic [31:0]   TC    = 32'(BEAT_DIV - 3);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      HOLD    = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [31:0]       cnt;
   logic              last;

   assign last    = ({1'b0, rd_ptr} == (song_len - ONE));
   assign state_o = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         note      <= '0;
         song_len  <= '0;
         overflow  <= 1'b0;
         play_done <= 1'b0;
      end else begin
         ram_we    <= 1'b0;
         play_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (play_en && song_len != '0) begin
                  state    <= RD_REQ;
                  rd_ptr   <= '0;
                  ram_addr <= '0;
               end else if (load_en) begin
                  state    <= LOAD;
                  wr_ptr   <= '0;
                  song_len <= '0;
                  overflow <= 1'b0;
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  if (song_len < FULL) begin
                     ram_we    <= 1'b1;
                     ram_addr  <= wr_ptr;
                     ram_wdata <= rx_data;
                     wr_ptr    <= wr_ptr + 1'b1;
                     song_len  <= song_len + ONE;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               if (!load_en) state <= IDLE;
            end
            RD_REQ: begin
               if (!play_en) begin
                  state <= IDLE;
                  note  <= '0;
               end else begin
                  state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (!play_en) begin
                  state <= IDLE;
                  note  <= '0;
               end else begin
                  note  <= ram_rdata[NOTE_W-1:0];
                  cnt   <= '0;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (!play_en) begin
                  state <= IDLE;
                  note  <= '0;
               end else if (cnt == TC) begin
                  if (last) begin
                     play_done <= 1'b1;
`ifdef NOTE_RAM_SEQ_LOOP_EN
                     rd_ptr    <= '0;
                     ram_addr  <= '0;
                     state     <= RD_REQ;
`else
                     note      <= '0;
                     state     <= DONE;
`endif
                  end else begin
                     rd_ptr   <= rd_ptr + 1'b1;
                     ram_addr <= rd_ptr + 1'b1;
                     state    <= RD_REQ;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (!play_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
